vram_write_scheduler: RTL and testbench

VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

---
 rtl/vram_write_scheduler.sv | 114 +++++++++++
 tb/tb_vram_write_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vram_write_scheduler.sv
// Arbitrates CPU pixel writes (via a small FIFO) against a full-screen fill sweep,
// producing a single registered write port into the video memory.
module vram_write_scheduler #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DEPTH       = 96000,
  parameter int COLOR_WIDTH = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   iClk,
  input  logic                   iRstN,
  input  logic                   iCpuWrite,
  input  logic [ADDR_WIDTH-1:0]  iCpuAddr,
  input  logic [COLOR_WIDTH-1:0] iCpuColor,
  output logic                   oCpuReady,
  input  logic                   iFillStart,
  input  logic [COLOR_WIDTH-1:0] iFillColor,
  output logic                   oFillBusy,
  output logic                   oFillDone,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddr,
  output logic [COLOR_WIDTH-1:0] oWriteColor
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  fifoAddr  [FIFO_DEPTH];
  logic [COLOR_WIDTH-1:0] fifoColor [FIFO_DEPTH];
  logic [PTR_W-1:0]       wrPtr;
  logic [PTR_W-1:0]       rdPtr;
  logic [CNT_W-1:0]       count;
  logic [ADDR_WIDTH-1:0]  fillCnt;
  logic [COLOR_WIDTH-1:0] fillColor;
  logic                   push;
  logic                   pop;

  // Ready comes only from the registered count, so it never depends on this cycle's request.
  assign oCpuReady = (count != FULL_CNT);
  assign push      = iCpuWrite && oCpuReady;
  assign pop       = (state == IDLE) && (count != '0);

  // Buffer storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge iClk) begin
    if (push) begin
      fifoAddr[wrPtr]  <= iCpuAddr;
      fifoColor[wrPtr] <= iCpuColor;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
      if (pop)  rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state        <= IDLE;
      fillCnt      <= '0;
      fillColor    <= '0;
      oFillBusy    <= 1'b0;
      oFillDone    <= 1'b0;
      oWriteEnable <= 1'b0;
      oWriteAddr   <= '0;
      oWriteColor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          oFillDone    <= 1'b0;
          oWriteEnable <= pop;
          if (pop) begin
            oWriteAddr  <= fifoAddr[rdPtr];
            oWriteColor <= fifoColor[rdPtr];
          end
          // A coincident pop still completes; the sweep begins on the next edge.
          if (iFillStart) begin
            fillColor <= iFillColor;
            fillCnt   <= '0;
            state     <= FILL;
            oFillBusy <= 1'b1;
          end
        end
        FILL: begin
          oWriteEnable <= 1'b1;
          oWriteAddr   <= fillCnt;
          oWriteColor  <= fillColor;
          oFillDone    <= 1'b0;
          if (fillCnt == LAST_ADDR) begin
            state     <= IDLE;
            oFillBusy <= 1'b0;
            oFillDone <= 1'b1;
            fillCnt   <= '0;
          end else begin
            fillCnt <= fillCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler with a 16-location memory and a 4-entry buffer.
module tb_vram_write_scheduler;

  localparam int AW = 17;
  localparam int CW = 3;

  logic          clk;
  logic          rstN;
  logic          cpuWrite;
  logic [AW-1:0] cpuAddr;
  logic [CW-1:0] cpuColor;
  logic          cpuReady;
  logic          fillStart;
  logic [CW-1:0] fillColor;
  logic          fillBusy;
  logic          fillDone;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [CW-1:0] wColor;

  int checks = 0;
  int errors = 0;

  vram_write_scheduler #(
    .ADDR_WIDTH(AW), .DEPTH(16), .COLOR_WIDTH(CW), .FIFO_DEPTH(4)
  ) dut (
    .iClk(clk), .iRstN(rstN),
    .iCpuWrite(cpuWrite), .iCpuAddr(cpuAddr), .iCpuColor(cpuColor), .oCpuReady(cpuReady),
    .iFillStart(fillStart), .iFillColor(fillColor), .oFillBusy(fillBusy), .oFillDone(fillDone),
    .oWriteEnable(we), .oWriteAddr(wAddr), .oWriteColor(wColor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkWrite(input string tag, input logic [31:0] eWe,
                          input logic [31:0] eAddr, input logic [31:0] eColor);
    chk({tag, "_we"}, 32'(we), eWe);
    if (eWe == 32'd1) begin
      chk({tag, "_addr"}, 32'(wAddr), eAddr);
      chk({tag, "_color"}, 32'(wColor), eColor);
    end
  endtask

  initial begin
    bit sawDone;
    int weCount;

    rstN = 1'b0; cpuWrite = 1'b0; cpuAddr = '0; cpuColor = '0;
    fillStart = 1'b0; fillColor = '0;

    // Reset state
    #12;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(wAddr), 32'd0);
    chk("rst_color", 32'(wColor), 32'd0);
    chk("rst_busy", 32'(fillBusy), 32'd0);
    chk("rst_done", 32'(fillDone), 32'd0);
    chk("rst_ready", 32'(cpuReady), 32'd1);
    rstN = 1'b1;

    // Idle write: push at edge k, visible only after edge k+1
    cpuWrite = 1'b1; cpuAddr = 17'd5; cpuColor = 3'b101;
    tick();
    cpuWrite = 1'b0;
    chk("idle_k_we", 32'(we), 32'd0);
    tick();
    chkWrite("idle_k1", 32'd1, 32'd5, 32'd5);
    tick();
    chk("idle_k2_we", 32'(we), 32'd0);

    // Full fill sweep
    fillStart = 1'b1; fillColor = 3'b010;
    tick();
    fillStart = 1'b0;
    chk("fill_start_busy", 32'(fillBusy), 32'd1);
    chk("fill_start_we", 32'(we), 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chkWrite("fill", 32'd1, 32'(i), 32'd2);
      chk("fill_busy", 32'(fillBusy), (i == 15) ? 32'd0 : 32'd1);
      chk("fill_done", 32'(fillDone), (i == 15) ? 32'd1 : 32'd0);
    end
    tick();
    chk("fill_after_done", 32'(fillDone), 32'd0);
    chk("fill_after_we", 32'(we), 32'd0);

    // Back-pressure during fill: four accepted, fifth dropped
    fillStart = 1'b1; fillColor = 3'b001;
    tick();
    fillStart = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      cpuWrite = 1'b1; cpuAddr = AW'(j); cpuColor = CW'(j);
      chk("bp_ready_pre", 32'(cpuReady), (j <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    cpuWrite = 1'b0;
    chk("bp_ready_full", 32'(cpuReady), 32'd0);
    sawDone = 1'b0;
    for (int n = 0; n < 40 && !sawDone; n++) begin
      tick();
      if (fillDone) sawDone = 1'b1;
    end
    chk("bp_saw_done", 32'(sawDone), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chkWrite("bp_pop", 32'd1, 32'(j), 32'(j));
      chk("bp_ready_post", 32'(cpuReady), 32'd1);
    end
    tick();
    chk("bp_drop_we", 32'(we), 32'd0);

    // Simultaneous push and pop keeps order
    cpuWrite = 1'b1; cpuAddr = 17'd10; cpuColor = 3'd3;
    tick();
    chk("sim_s1_we", 32'(we), 32'd0);
    cpuAddr = 17'd11; cpuColor = 3'd4;
    tick();
    chkWrite("sim_s2", 32'd1, 32'd10, 32'd3);
    cpuAddr = 17'd12; cpuColor = 3'd6;
    tick();
    chkWrite("sim_s3", 32'd1, 32'd11, 32'd4);
    chk("sim_ready", 32'(cpuReady), 32'd1);
    cpuWrite = 1'b0;
    tick();
    chkWrite("sim_s4", 32'd1, 32'd12, 32'd6);
    tick();
    chk("sim_s5_we", 32'(we), 32'd0);

    // Restart request mid-fill is ignored
    fillStart = 1'b1; fillColor = 3'b011;
    tick();
    fillStart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fillStart = (i == 9); fillColor = (i == 9) ? 3'b111 : 3'b011;
      tick();
      chkWrite("rs_fill", 32'd1, 32'(i), 32'd3);
      chk("rs_done", 32'(fillDone), (i == 15) ? 32'd1 : 32'd0);
    end
    fillStart = 1'b0;
    tick();
    chk("rs_after_done", 32'(fillDone), 32'd0);
    chk("rs_after_we", 32'(we), 32'd0);
    chk("rs_after_busy", 32'(fillBusy), 32'd0);

    // Reset mid-fill with two buffered writes
    fillStart = 1'b1; fillColor = 3'b110;
    tick();
    fillStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cpuWrite = (i < 2); cpuAddr = AW'(20 + i); cpuColor = CW'(i + 1);
      tick();
      chkWrite("mr_fill", 32'd1, 32'(i), 32'd6);
    end
    cpuWrite = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("mr_we", 32'(we), 32'd0);
    chk("mr_addr", 32'(wAddr), 32'd0);
    chk("mr_color", 32'(wColor), 32'd0);
    chk("mr_busy", 32'(fillBusy), 32'd0);
    chk("mr_done", 32'(fillDone), 32'd0);
    chk("mr_ready", 32'(cpuReady), 32'd1);
    #4 rstN = 1'b1;
    weCount = 0;
    for (int n = 0; n < 24; n++) begin
      tick();
      if (we) weCount++;
    end
    chk("mr_no_writes", 32'(weCount), 32'd0);
    chk("mr_ready_after", 32'(cpuReady), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
